axis_mash_dsm: RTL



---
 rtl/axis_mash_dsm_pkg.sv | 21 ++
 rtl/axis_mash_dsm_stage.sv | 48 ++++
 rtl/axis_mash_dsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axis_mash_dsm_pkg.sv
// Shared constants and types for the MASH delta-sigma modulator.
// Optional dither is enabled with AXIS_MASH_DSM_DITHER_EN.
package axis_mash_dsm_pkg;

  localparam int STAGES_MAX = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for the right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic c;
    logic c_d1;
    logic c_d2;
  } carry_hist_t;

  function automatic int out_width(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/axis_mash_dsm_stage.sv
// One first-order error-feedback accumulator of the MASH cascade, with its
// carry and a two-step carry delay line for the noise-cancellation network.
module mash_efm_stage
  import axis_mash_dsm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             step,
  input  logic [WIDTH-1:0] in_k,
  output logic [WIDTH-1:0] s_k_low,
  output carry_hist_t      carry
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_d1_q, c_d1_d;
  logic             c_d2_q, c_d2_d;
  logic [WIDTH:0]   s_k;

  always_comb begin
    s_k    = {1'b0, acc_q} + {1'b0, in_k};
    acc_d  = acc_q;
    c_d1_d = c_d1_q;
    c_d2_d = c_d2_q;
    if (step) begin
      acc_d  = s_k[WIDTH-1:0];
      c_d1_d = s_k[WIDTH];
      c_d2_d = c_d1_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      acc_q  <= '0;
      c_d1_q <= 1'b0;
      c_d2_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      c_d1_q <= c_d1_d;
      c_d2_q <= c_d2_d;
    end
  end

  assign s_k_low = s_k[WIDTH-1:0];
  assign carry   = {s_k[WIDTH], c_d1_q, c_d2_q};

endmodule

// File: rtl/axis_mash_dsm.sv
// AXI-Stream MASH 1..3 delta-sigma modulator with OSR-fold zero-order hold.
// Define AXIS_MASH_DSM_DITHER_EN to add LFSR dither on the first stage input.
module axis_mash_dsm
  import axis_mash_dsm_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  parameter  int OSR    = 4,
  localparam int OUT_W  = out_width(STAGES)
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic [WIDTH-1:0]        s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic signed [OUT_W-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WIDTH-1:0]        m_axis_terror,
  output logic                    underrun
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int YW    = out_width(STAGES_MAX);

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("axis_mash_dsm: STAGES must be in 1..3");
  end
  if (OSR < 1) begin : g_bad_osr
    $error("axis_mash_dsm: OSR must be at least 1");
  end

  logic [WIDTH-1:0]        x_q, x_d;
  logic                    have_x_q, have_x_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    seen_q, seen_d;
  logic signed [OUT_W-1:0] tdata_q, tdata_d;
  logic [WIDTH-1:0]        terror_q, terror_d;
  logic                    tvalid_q, tvalid_d;

  logic             step, last, accept;
  logic [WIDTH-1:0] u, in1;

  assign step          = have_x_q & (~tvalid_q | m_axis_tready);
  assign last          = (cnt_q == CNT_W'(OSR - 1));
  assign s_axis_tready = ~have_x_q | (step & last);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign underrun      = ~have_x_q & (~tvalid_q | m_axis_tready) & seen_q;

  // Offset binary so that full-scale negative maps to an all-zero density
  assign u = {~x_q[WIDTH-1], x_q[WIDTH-2:0]};

`ifdef AXIS_MASH_DSM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign in1 = u + WIDTH'(lfsr_q[0]);
`else
  assign in1 = u;
`endif

  // Cascade: absent stages contribute zero carries to the cancellation sum
  carry_hist_t      hist     [STAGES_MAX];
  logic [WIDTH-1:0] s_low    [STAGES_MAX];
  logic [WIDTH-1:0] stage_in [STAGES_MAX];

  genvar gi;
  for (gi = 0; gi < STAGES_MAX; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_in[gi] = in1;
    end else begin : g_next
      assign stage_in[gi] = s_low[gi-1];
    end

    if (gi < STAGES) begin : g_on
      mash_efm_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .step    (step),
        .in_k    (stage_in[gi]),
        .s_k_low (s_low[gi]),
        .carry   (hist[gi])
      );
    end else begin : g_off
      assign s_low[gi] = '0;
      assign hist[gi]  = '0;
    end
  end

  function automatic logic signed [YW-1:0] bit_s(input logic b);
    return {{(YW-1){1'b0}}, b};
  endfunction

  logic signed [YW-1:0]    y_full;
  logic signed [OUT_W-1:0] y;

  always_comb begin
    y_full = bit_s(hist[0].c)
           + (bit_s(hist[1].c) - bit_s(hist[1].c_d1))
           + (bit_s(hist[2].c) - (bit_s(hist[2].c_d1) <<< 1) + bit_s(hist[2].c_d2));
    y      = y_full[OUT_W-1:0];
  end

  logic unused_sink;
  assign unused_sink = ^{y_full, hist[0].c_d1, hist[0].c_d2, hist[1].c_d2,
                         s_low[STAGES_MAX-1], stage_in[STAGES_MAX-1]};

  always_comb begin
    x_d      = x_q;
    have_x_d = have_x_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q | accept;
    tdata_d  = tdata_q;
    terror_d = terror_q;
    tvalid_d = tvalid_q & ~m_axis_tready;

    if (step) begin
      cnt_d    = last ? '0 : cnt_q + 1'b1;
      tvalid_d = 1'b1;
      tdata_d  = y;
      terror_d = s_low[STAGES-1];
      if (last) begin
        have_x_d = 1'b0;
      end
    end

    // A new sample on the final step keeps the hold register full
    if (accept) begin
      x_d      = s_axis_tdata;
      have_x_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      x_q      <= '0;
      have_x_q <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      tdata_q  <= '0;
      terror_q <= '0;
      tvalid_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      have_x_q <= have_x_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      tdata_q  <= tdata_d;
      terror_q <= terror_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_terror = terror_q;
  assign m_axis_tvalid = tvalid_q;

endmodule
